ps2_key_input: RTL and testbench

//  PS/2 keyboard receiver that drives the falling-letter column FSMs' user_input byte.

---
 rtl/ps2_key_input.sv | 245 ++++++++++++++++++++++++
 tb/tb_ps2_key_input.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_input.sv
// -----------------------------------------------------------------------------
// ps2_key_input
//
// Purpose:
//   PS/2 keyboard receiver for the falling-letter game. Conditions the raw
//   PS/2 clock/data pins, assembles and validates 11-bit frames (start, 8 data
//   bits LSB first, odd parity, stop), then tracks make/break/extended codes.
//   The make code of the currently held key is presented on user_input, and
//   8'h00 means "no key held". This block only receives and never drives the
//   PS/2 lines.
//
// Ports:
//   clock          in   1  system clock (50 MHz), all logic on posedge
//   reset_signal   in   1  synchronous, active-low reset
//   ps2_clk        in   1  raw PS/2 clock pin (asynchronous)
//   ps2_data       in   1  raw PS/2 data pin (asynchronous)
//   user_input     out  8  make code of the held key, 8'h00 = none
//   key_valid      out  1  one-cycle pulse when user_input takes a new key
//   key_held       out  1  high while user_input != 8'h00
//   frame_error    out  1  one-cycle pulse on parity/stop/timeout error
//   present_state  out  3  receiver FSM state, for debug display
// -----------------------------------------------------------------------------
module ps2_key_input #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset_signal,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] user_input,
    output logic       key_valid,
    output logic       key_held,
    output logic       frame_error,
    output logic [2:0] present_state
);

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        DECODE = 3'd4,
        ERROR  = 3'd5
    } state_t;

    // Odd parity check: data bits plus parity bit must contain an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // Synchroniser and glitch-filter state
    logic             clk_s1_q, clk_s2_q;
    logic             dat_s1_q, dat_s2_q;
    logic             filt_q, filt_d;
    logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
    logic             fall_s;

    // Frame receiver and key-tracking state
    state_t           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic             par_ok_q, par_ok_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             brk_q, brk_d;
    logic             ext_q, ext_d;
    logic [7:0]       user_q, user_d;
    logic             held_q, held_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // Two-flop synchronisers and the filtered-clock register; idle line level is 1.
    always_ff @(posedge clock) begin
        if (!reset_signal) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            filt_q    <= 1'b1;
            flt_cnt_q <= {FLT_W{1'b0}};
        end else begin
            clk_s1_q  <= ps2_clk;
            clk_s2_q  <= clk_s1_q;
            dat_s1_q  <= ps2_data;
            dat_s2_q  <= dat_s1_q;
            filt_q    <= filt_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    // Glitch filter: the filtered clock follows only after FILTER_LEN
    // consecutive synced samples at the opposite level. fall_s marks the
    // cycle in which a 1->0 change is committed; data is sampled then.
    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = {FLT_W{1'b0}};
        fall_s    = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
                fall_s = filt_q;
            end else begin
                flt_cnt_d = flt_cnt_q + {{(FLT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            flt_cnt_d = {FLT_W{1'b0}};
        end
    end

    // Receiver FSM next state plus decode of make/break/extended sequences.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        par_ok_d = par_ok_q;
        tmo_d    = tmo_q;
        brk_d    = brk_q;
        ext_d    = ext_q;
        user_d   = user_q;
        held_d   = held_q;
        valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                tmo_d = {TMO_W{1'b0}};
                // A fall with data high is line noise, not a start bit.
                if (fall_s && !dat_s2_q) begin
                    state_d  = DATA;
                    bitcnt_d = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA, PARITY, STOP: begin
                if (fall_s) begin
                    tmo_d = {TMO_W{1'b0}};
                    if (state_q == DATA) begin
                        shift_d = {dat_s2_q, shift_q[7:1]};
                        if (bitcnt_q == 3'd7) begin
                            state_d = PARITY;
                        end else begin
                            bitcnt_d = bitcnt_q + 3'd1;
                        end
                    end else if (state_q == PARITY) begin
                        par_ok_d = odd_parity_ok(shift_q, dat_s2_q);
                        state_d  = STOP;
                    end else begin
                        if (dat_s2_q && par_ok_q) begin
                            state_d = DECODE;
                        end else begin
                            state_d = ERROR;
                        end
                    end
                end else begin
                    // Keyboard stalled mid-frame: abandon it after the timeout.
                    tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
                    if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d = ERROR;
                    end else begin
                        state_d = state_q;
                    end
                end
            end
            DECODE: begin
                state_d = IDLE;
                if (shift_q == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (shift_q == 8'hF0) begin
                    brk_d = 1'b1;
                end else if (brk_q) begin
                    // Only a plain break of the held key releases it.
                    if (!ext_q && (shift_q == user_q)) begin
                        user_d = 8'h00;
                        held_d = 1'b0;
                    end else begin
                        user_d = user_q;
                    end
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end else if (ext_q) begin
                    // Extended keys are not game letters; drop the make code.
                    ext_d = 1'b0;
                end else if ((shift_q == user_q) || (shift_q == 8'h00)) begin
                    // Typematic repeat of the held key (or a null byte): no event.
                    user_d = user_q;
                end else begin
                    user_d  = shift_q;
                    held_d  = 1'b1;
                    valid_d = 1'b1;
                end
            end
            ERROR: begin
                state_d = IDLE;
                tmo_d   = {TMO_W{1'b0}};
                brk_d   = 1'b0;
                ext_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // frame_error is high exactly while the FSM sits in ERROR.
        ferr_d = (state_d == ERROR);
    end

    // FSM and output registers.
    always_ff @(posedge clock) begin
        if (!reset_signal) begin
            state_q  <= IDLE;
            shift_q  <= 8'h00;
            bitcnt_q <= 3'd0;
            par_ok_q <= 1'b0;
            tmo_q    <= {TMO_W{1'b0}};
            brk_q    <= 1'b0;
            ext_q    <= 1'b0;
            user_q   <= 8'h00;
            held_q   <= 1'b0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            par_ok_q <= par_ok_d;
            tmo_q    <= tmo_d;
            brk_q    <= brk_d;
            ext_q    <= ext_d;
            user_q   <= user_d;
            held_q   <= held_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
        end
    end

    assign user_input    = user_q;
    assign key_valid     = valid_q;
    assign key_held      = held_q;
    assign frame_error   = ferr_q;
    assign present_state = state_q;

endmodule

// File: tb/tb_ps2_key_input.sv
// -----------------------------------------------------------------------------
// tb_ps2_key_input
//
// Drives hand-built PS/2 frames into ps2_key_input. Each stimulus step that
// should produce a key_valid or frame_error pulse pushes the expected event
// (kind, user_input value, latency from the last driven ps2_clk fall) into a
// queue; an independent monitor pops and compares whenever the DUT pulses.
//
// Latency reference: ps2_clk is driven low at a negedge. Two synchroniser
// flops plus FILTER_LEN filter samples put the internal fall at the 6th
// posedge (FILTER_LEN=4). STOP->ERROR is therefore visible after posedge 6,
// STOP->DECODE->register after posedge 7, and a timeout after 6+TMO.
// -----------------------------------------------------------------------------
module tb_ps2_key_input;

    localparam int FLT = 4;
    localparam int TMO = 2000;
    localparam int H   = 8;           // half PS/2 bit period, in system clocks
    localparam int LAT_FALL  = 2 + FLT;
    localparam int LAT_KEY   = LAT_FALL + 1;
    localparam int LAT_TOUT  = LAT_FALL + TMO;

    typedef struct {
        logic       is_err;
        logic [7:0] val;
        int         lat;
    } exp_t;

    logic       clock;
    logic       reset_signal;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] user_input;
    logic       key_valid;
    logic       key_held;
    logic       frame_error;
    logic [2:0] present_state;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_fall_cyc = 0;
    exp_t exp_q[$];

    ps2_key_input #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
        .clock        (clock),
        .reset_signal (reset_signal),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .user_input   (user_input),
        .key_valid    (key_valid),
        .key_held     (key_held),
        .frame_error  (frame_error),
        .present_state(present_state)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    // Scoreboard monitor: every output pulse must match the next queued expectation.
    always @(negedge clock) begin
        if (key_valid === 1'b1 && frame_error === 1'b1) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL overlap: key_valid and frame_error both high at cycle %0d", cyc);
        end else if (key_valid === 1'b1 || frame_error === 1'b1) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_event: got valid=%b err=%b user=%h, required no event",
                         key_valid, frame_error, user_input);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (frame_error !== e.is_err || user_input !== e.val ||
                    key_held !== (e.val != 8'h00) || (cyc - last_fall_cyc) != e.lat ||
                    (e.is_err && present_state !== 3'd5)) begin
                    errors = errors + 1;
                    $display("FAIL event: got err=%b user=%h held=%b lat=%0d state=%0d, required err=%b user=%h held=%b lat=%0d",
                             frame_error, user_input, key_held, cyc - last_fall_cyc, present_state,
                             e.is_err, e.val, (e.val != 8'h00), e.lat);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_evt(input logic is_err, input logic [7:0] val, input int lat);
        exp_t e;
        e.is_err = is_err;
        e.val    = val;
        e.lat    = lat;
        exp_q.push_back(e);
    endtask

    // One PS/2 bit: set data while clock high, then a full low/high clock period.
    task automatic ps2_bit(input logic d);
        ps2_data = d;
        repeat (H) @(negedge clock);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (H) @(negedge clock);
        ps2_clk = 1'b1;
    endtask

    task automatic idle_gap();
        ps2_data = 1'b1;
        repeat (12) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic flip_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ flip_par);
        ps2_bit(1'b1);
        idle_gap();
    endtask

    task automatic check_level(input string name, input logic [7:0] val);
        chk({name, "_user"}, user_input, val);
        chk({name, "_held"}, key_held, (val != 8'h00));
        chk({name, "_state"}, present_state, 0);
    endtask

    initial begin
        logic [7:0] b1c;
        b1c = 8'h1C;
        reset_signal = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clock);
        reset_signal = 1'b1;

        // Reset state
        chk("rst_user", user_input, 0);
        chk("rst_valid", key_valid, 0);
        chk("rst_held", key_held, 0);
        chk("rst_ferr", frame_error, 0);
        chk("rst_state", present_state, 0);

        // 1: single make code 0x1C
        expect_evt(1'b0, 8'h1C, LAT_KEY);
        send_byte(8'h1C, 1'b0);
        check_level("t1", 8'h1C);
        send_byte(8'h1C, 1'b0);            // typematic repeat, no pulse
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        check_level("t1_release", 8'h00);

        // 2: 1C,1C,F0,1C gives exactly one key_valid then release
        expect_evt(1'b0, 8'h1C, LAT_KEY);
        send_byte(8'h1C, 1'b0);
        send_byte(8'h1C, 1'b0);
        send_byte(8'hF0, 1'b0);
        check_level("t2_break_pend", 8'h1C);
        send_byte(8'h1C, 1'b0);
        check_level("t2", 8'h00);

        // 3: parity error leaves held key intact, next good key overrides
        expect_evt(1'b0, 8'h1C, LAT_KEY);
        send_byte(8'h1C, 1'b0);
        expect_evt(1'b1, 8'h1C, LAT_FALL);
        send_byte(8'h1C, 1'b1);
        check_level("t3_err", 8'h1C);
        expect_evt(1'b0, 8'h32, LAT_KEY);
        send_byte(8'h32, 1'b0);
        check_level("t3", 8'h32);

        // 4: line stops after 5 data bits -> timeout error
        expect_evt(1'b1, 8'h32, LAT_TOUT);
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(b1c[i]);
        ps2_data = 1'b1;
        repeat (LAT_TOUT + 10) @(negedge clock);
        check_level("t4_tout", 8'h32);
        expect_evt(1'b0, 8'h1C, LAT_KEY);
        send_byte(8'h1C, 1'b0);
        check_level("t4", 8'h1C);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        check_level("t4_release", 8'h00);

        // 5: extended make and extended break are ignored
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        check_level("t5", 8'h00);
        // 2-cycle low glitch with data low would look like a start bit if it got through
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (2) @(negedge clock);
        ps2_clk  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("t5_glitch_state", present_state, 0);
        end
        ps2_data = 1'b1;
        repeat (4) @(negedge clock);

        // 6: reset mid-frame clears outputs and discards the partial frame
        expect_evt(1'b0, 8'h32, LAT_KEY);
        send_byte(8'h32, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(b1c[i]);
        reset_signal = 1'b0;
        @(negedge clock);
        reset_signal = 1'b1;
        chk("t6_rst_user", user_input, 0);
        chk("t6_rst_held", key_held, 0);
        chk("t6_rst_valid", key_valid, 0);
        chk("t6_rst_ferr", frame_error, 0);
        chk("t6_rst_state", present_state, 0);
        // Leftover bits 1,0,0,0,par0,stop1: the 1 is ignored in IDLE, the next
        // 0 looks like a start bit, so the remainder forms a short frame that
        // times out without touching user_input.
        expect_evt(1'b1, 8'h00, LAT_TOUT);
        for (int i = 4; i < 8; i++) ps2_bit(b1c[i]);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (LAT_TOUT + 10) @(negedge clock);
        check_level("t6_tout", 8'h00);
        expect_evt(1'b0, 8'h1C, LAT_KEY);
        send_byte(8'h1C, 1'b0);
        check_level("t6", 8'h1C);

        repeat (20) @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
